// File: rtl/debounced_switch_lut.sv
// debounced_switch_lut: synchronises and debounces NUM_SW raw switch inputs, then looks up the
// stable switch vector in a truth table to drive NUM_LED registered LED outputs.
// o_Change pulses for one cycle whenever the LED register takes a new value.
//
// Optional feature macro: SWITCH_LUT_PROG_EN
//   undefined - table is the constant LUT_INIT; no programming ports.
//   defined   - table is a register array reset to LUT_INIT and written one row at a time
//               through i_Prog_Wr / i_Prog_Addr / i_Prog_Data.

module debounced_switch_lut #(
  parameter int unsigned NUM_SW         = 2,
  parameter int unsigned NUM_LED        = 1,
  parameter int unsigned DEBOUNCE_LIMIT = 250000,
  parameter logic [NUM_LED*(2**NUM_SW)-1:0] LUT_INIT = {NUM_LED{4'b1001}}
) (
  input  logic               i_Clk,
  input  logic               i_Rst_L,
  input  logic [NUM_SW-1:0]  i_Switch,
`ifdef SWITCH_LUT_PROG_EN
  input  logic               i_Prog_Wr,
  input  logic [NUM_SW-1:0]  i_Prog_Addr,
  input  logic [NUM_LED-1:0] i_Prog_Data,
`endif
  output logic [NUM_LED-1:0] o_LED,
  output logic               o_Change
);

  localparam int unsigned NumRows = 2 ** NUM_SW;
  localparam int unsigned CntW    = $clog2(DEBOUNCE_LIMIT + 1);
  // Last count value before a pending change is accepted; the counter never goes past it.
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_LIMIT - 1);

  // Synchroniser and debounce state, one lane per switch.
  logic [NUM_SW-1:0] sync1_q, sync2_q;
  logic [NUM_SW-1:0] deb_q, deb_d;
  logic [CntW-1:0]   cnt_q [NUM_SW];
  logic [CntW-1:0]   cnt_d [NUM_SW];

  // Output stage.
  logic [NUM_LED-1:0] led_q, led_d;
  logic               change_q, change_d;

  // Truth-table rows seen by the lookup.
  logic [NUM_LED-1:0] table_rows [NumRows];

  // Two-flop synchroniser for the raw asynchronous pins.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= i_Switch;
      sync2_q <= sync1_q;
    end
  end

  // Per-switch debounce: count while synced and debounced disagree, accept on the last count.
  always_comb begin
    deb_d = deb_q;
    for (int unsigned i = 0; i < NUM_SW; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == CntMax) begin
          deb_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Debounce state registers; a bounce back to equality clears the count via cnt_d.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      deb_q <= '0;
      for (int unsigned i = 0; i < NUM_SW; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      deb_q <= deb_d;
      for (int unsigned i = 0; i < NUM_SW; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

`ifdef SWITCH_LUT_PROG_EN
  logic [NUM_LED-1:0] table_q [NumRows];

  // Programmable table: reloads LUT_INIT on reset, one row written per i_Prog_Wr cycle.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      for (int unsigned r = 0; r < NumRows; r++) begin
        table_q[r] <= LUT_INIT[r*NUM_LED +: NUM_LED];
      end
    end else if (i_Prog_Wr) begin
      table_q[i_Prog_Addr] <= i_Prog_Data;
    end
  end

  // Lookup reads the registered table, so a write is visible to o_LED one cycle later.
  always_comb begin
    for (int unsigned r = 0; r < NumRows; r++) begin
      table_rows[r] = table_q[r];
    end
  end
`else
  // Constant table sliced from LUT_INIT; collapses to plain logic.
  always_comb begin
    for (int unsigned r = 0; r < NumRows; r++) begin
      table_rows[r] = LUT_INIT[r*NUM_LED +: NUM_LED];
    end
  end
`endif

  // Next LED value and change flag from the debounced vector.
  always_comb begin
    led_d    = table_rows[deb_q];
    change_d = (led_d != led_q);
  end

  // LED and change-pulse registers.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      led_q    <= '0;
      change_q <= 1'b0;
    end else begin
      led_q    <= led_d;
      change_q <= change_d;
    end
  end

  assign o_LED    = led_q;
  assign o_Change = change_q;

endmodule

// File: tb/tb_debounced_switch_lut.sv
// Directed bench for debounced_switch_lut: a 2-switch/1-LED instance with DEBOUNCE_LIMIT 4 and
// an XNOR table, plus a 4-switch/2-LED instance with DEBOUNCE_LIMIT 1 and an arbitrary table.

module tb_debounced_switch_lut;

  localparam int unsigned Limit = 4;
  localparam logic [31:0] Lut4  = 32'hB4E1_7C29;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] sw;
  logic       led;
  logic       chg;
  logic [3:0] sw4;
  logic [1:0] led4;
  logic       chg4;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

`ifdef SWITCH_LUT_PROG_EN
  logic       prog_wr;
  logic [1:0] prog_addr;
  logic       prog_data;
  logic       prog4_wr;
  logic [3:0] prog4_addr;
  logic [1:0] prog4_data;
`endif

  debounced_switch_lut #(
    .NUM_SW        (2),
    .NUM_LED       (1),
    .DEBOUNCE_LIMIT(Limit),
    .LUT_INIT      (4'b1001)
  ) dut (
    .i_Clk      (clk),
    .i_Rst_L    (rst_n),
    .i_Switch   (sw),
`ifdef SWITCH_LUT_PROG_EN
    .i_Prog_Wr  (prog_wr),
    .i_Prog_Addr(prog_addr),
    .i_Prog_Data(prog_data),
`endif
    .o_LED      (led),
    .o_Change   (chg)
  );

  debounced_switch_lut #(
    .NUM_SW        (4),
    .NUM_LED       (2),
    .DEBOUNCE_LIMIT(1),
    .LUT_INIT      (Lut4)
  ) dut4 (
    .i_Clk      (clk),
    .i_Rst_L    (rst_n),
    .i_Switch   (sw4),
`ifdef SWITCH_LUT_PROG_EN
    .i_Prog_Wr  (prog4_wr),
    .i_Prog_Addr(prog4_addr),
    .i_Prog_Data(prog4_data),
`endif
    .o_LED      (led4),
    .o_Change   (chg4)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance one clock; sample and drive 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [1:0] sw;
    logic       led;
    logic       chg;
    int         pulses;
  } step_t;

  step_t steps [4];

  initial begin
    logic       led_exp;
    int         pulses;
    int         moved;
    logic [1:0] row;
    logic [1:0] prev_row;
    logic [31:0] lut;

    steps[0] = '{sw: 2'b01, led: 1'b0, chg: 1'b1, pulses: 1};
    steps[1] = '{sw: 2'b10, led: 1'b0, chg: 1'b0, pulses: 0};
    steps[2] = '{sw: 2'b11, led: 1'b1, chg: 1'b1, pulses: 1};
    steps[3] = '{sw: 2'b00, led: 1'b1, chg: 1'b0, pulses: 0};

    rst_n = 1'b0;
    sw    = 2'b00;
    sw4   = 4'h0;
`ifdef SWITCH_LUT_PROG_EN
    prog_wr    = 1'b0;
    prog_addr  = 2'b00;
    prog_data  = 1'b0;
    prog4_wr   = 1'b0;
    prog4_addr = 4'h0;
    prog4_data = 2'b00;
`endif

    // Reset and first clock after release.
    tick();
    tick();
    check("reset_led", 32'(led), 32'd0);
    check("reset_chg", 32'(chg), 32'd0);
    rst_n = 1'b1;
    tick();
    check("release_led", 32'(led), 32'd1);
    check("release_chg", 32'(chg), 32'd1);
    tick();
    check("release_chg_end", 32'(chg), 32'd0);
    led_exp = 1'b1;

    // Bounces of 3 cycles never reach the 4-cycle limit.
    moved = 0;
    for (int rep = 0; rep < 5; rep++) begin
      sw = 2'b01;
      for (int k = 0; k < 3; k++) begin
        tick();
        if (led !== 1'b1 || chg !== 1'b0) moved++;
      end
      sw = 2'b00;
      for (int k = 0; k < 3; k++) begin
        tick();
        if (led !== 1'b1 || chg !== 1'b0) moved++;
      end
    end
    for (int k = 0; k < 8; k++) begin
      tick();
      if (led !== 1'b1 || chg !== 1'b0) moved++;
    end
    check("bounce_moves", 32'(moved), 32'd0);

    // Stepped switch vectors: update lands exactly 7 cycles after the pin edge.
    for (int i = 0; i < 4; i++) begin
      sw     = steps[i].sw;
      pulses = 0;
      for (int k = 1; k <= 6; k++) begin
        tick();
        pulses += int'(chg);
      end
      check($sformatf("step%0d_led_before", i), 32'(led), 32'(led_exp));
      tick();
      pulses += int'(chg);
      check($sformatf("step%0d_led", i), 32'(led), 32'(steps[i].led));
      check($sformatf("step%0d_chg", i), 32'(chg), 32'(steps[i].chg));
      for (int k = 8; k <= 10; k++) begin
        tick();
        pulses += int'(chg);
      end
      check($sformatf("step%0d_pulses", i), 32'(pulses), 32'(steps[i].pulses));
      led_exp = steps[i].led;
    end

    // Reset mid-count: counter restarts, change accepted only after a full count.
    sw = 2'b01;
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("midrst_async_led", 32'(led), 32'd0);
    tick();
    check("midrst_led", 32'(led), 32'd0);
    check("midrst_chg", 32'(chg), 32'd0);
    rst_n = 1'b1;
    tick();
    check("midrst_release_led", 32'(led), 32'd1);
    for (int k = 2; k <= 6; k++) tick();
    check("midrst_led_held", 32'(led), 32'd1);
    tick();
    check("midrst_led_accept", 32'(led), 32'd0);
    check("midrst_chg_accept", 32'(chg), 32'd1);

`ifdef SWITCH_LUT_PROG_EN
    // Program row 3 to 0 with switches at 11, then confirm reset restores LUT_INIT.
    sw = 2'b11;
    for (int k = 0; k < 10; k++) tick();
    check("prog_pre_led", 32'(led), 32'd1);
    prog_wr   = 1'b1;
    prog_addr = 2'b11;
    prog_data = 1'b0;
    tick();
    prog_wr = 1'b0;
    check("prog_write_cycle_led", 32'(led), 32'd1);
    tick();
    check("prog_next_led", 32'(led), 32'd0);
    check("prog_next_chg", 32'(chg), 32'd1);
    rst_n = 1'b0;
    tick();
    check("prog_rst_led", 32'(led), 32'd0);
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) tick();
    check("prog_restored_led", 32'(led), 32'd1);
`endif

    // Wide instance: every switch vector, DEBOUNCE_LIMIT 1 gives a 4-cycle latency.
    lut      = Lut4;
    prev_row = led4;
    for (int v = 0; v < 16; v++) begin
      row = lut[v*2 +: 2];
      sw4 = 4'(v);
      for (int k = 0; k < 3; k++) tick();
      check($sformatf("wide%0d_before", v), 32'(led4), 32'(prev_row));
      tick();
      check($sformatf("wide%0d_led", v), 32'(led4), 32'(row));
      for (int k = 0; k < 6; k++) tick();
      check($sformatf("wide%0d_hold", v), 32'(led4), 32'(row));
      prev_row = row;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
